// File: rtl/lin_sched_pkg.sv
// Shared definitions for the LIN schedule sequencer: FSM states, table codes
// and the bit layout of a schedule ROM entry.
package lin_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_REQ   = 2'd2,
        ST_SLOT  = 2'd3
    } state_t;

    localparam logic [1:0] TBL_NORM = 2'b00;
    localparam logic [1:0] TBL_COLL = 2'b01;
    localparam logic [1:0] TBL_DIAG = 2'b10;

    localparam int ID_LSB   = 0;
    localparam int ID_MSB   = 5;
    localparam int SLOT_LSB = 8;
    localparam int SLOT_MSB = 15;
    localparam int LAST_BIT = 16;

    // Diagnostic outranks collision, which outranks the normal table.
    function automatic logic [1:0] pick_table(input logic diag, input logic coll);
        if (diag)
            return TBL_DIAG;
        else if (coll)
            return TBL_COLL;
        else
            return TBL_NORM;
    endfunction

endpackage

// File: rtl/lin_slot_timer.sv
// Slot timer: counts ticks down from a loaded slot length and remembers whether
// the frame completed while the slot was still running.
module lin_slot_timer #(
    parameter int SLOT_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clear,
    input  logic              load,
    input  logic [SLOT_W-1:0] load_value,
    input  logic              tick,
    input  logic              frame_done,
    output logic              expired,
    output logic              done
);

    logic [SLOT_W-1:0] count_reg;
    logic              done_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else if (load) begin
            count_reg <= load_value;
            done_reg  <= 1'b0;
        end else begin
            // Once the count has reached zero the slot is over: further ticks
            // and late completions are ignored.
            if (tick && count_reg != '0)
                count_reg <= count_reg - SLOT_W'(1);
            if (frame_done && count_reg != '0)
                done_reg <= 1'b1;
        end
    end

    assign expired = (count_reg == '0);
    assign done    = done_reg;

endmodule

// File: rtl/lin_schedule_sequencer.sv
// LIN master schedule sequencer: walks the selected schedule table, issues one
// header request per slot and times each slot in base ticks.
module lin_schedule_sequencer
    import lin_sched_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              SLOT_W      = 8,
    parameter logic [ADDR_W-1:0] NORM_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] COLL_BASE = 8'h40,
    parameter logic [ADDR_W-1:0] DIAG_BASE = 8'h80,
    parameter int              MAX_ENTRIES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_operation,
    input  logic              en_collision_table,
    input  logic              en_diagnostic_table,
    input  logic              tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              hdr_req,
    output logic [5:0]        hdr_id,
    input  logic              hdr_ack,
    input  logic              frame_done,
    output logic              slot_overrun,
    output logic [1:0]        active_table,
    output logic              busy
);

    localparam int IDX_W = $clog2(MAX_ENTRIES) + 1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [5:0]        hdr_id_reg, hdr_id_next;
    logic [SLOT_W-1:0] slot_len_reg, slot_len_next;
    logic              last_reg, last_next;
    logic [1:0]        active_table_reg, active_table_next;
    logic              overrun_reg, overrun_next;

    logic              timer_load, timer_clear, slot_expired, slot_done;
    logic [1:0]        req_table;
    logic [SLOT_W-1:0] slot_field;
    logic              reserved_unused;

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] tbl);
        case (tbl)
            TBL_COLL: return COLL_BASE;
            TBL_DIAG: return DIAG_BASE;
            default:  return NORM_BASE;
        endcase
    endfunction

    assign req_table       = pick_table(en_diagnostic_table, en_collision_table);
    assign slot_field      = SLOT_W'(rom_data[SLOT_MSB:SLOT_LSB]);
    assign reserved_unused = ^{rom_data[31:LAST_BIT+1], rom_data[SLOT_LSB-1:ID_MSB+1]};

    always_comb begin
        state_next        = state_reg;
        rom_addr_next     = rom_addr_reg;
        idx_next          = idx_reg;
        hdr_id_next       = hdr_id_reg;
        slot_len_next     = slot_len_reg;
        last_next         = last_reg;
        active_table_next = active_table_reg;
        overrun_next      = 1'b0;
        timer_load        = 1'b0;
        timer_clear       = 1'b0;

        if (!en_operation) begin
            // Disable wins over everything, including a same-cycle ack.
            state_next  = ST_IDLE;
            timer_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    active_table_next = req_table;
                    rom_addr_next     = base_of(req_table);
                    idx_next          = '0;
                    state_next        = ST_FETCH;
                end
                ST_FETCH: begin
                    hdr_id_next   = rom_data[ID_MSB:ID_LSB];
                    slot_len_next = (slot_field == '0) ? SLOT_W'(1) : slot_field;
                    last_next     = rom_data[LAST_BIT];
                    state_next    = ST_REQ;
                end
                ST_REQ: begin
                    if (hdr_ack) begin
                        timer_load = 1'b1;
                        state_next = ST_SLOT;
                    end
                end
                ST_SLOT: begin
                    if (slot_expired) begin
                        overrun_next = !slot_done;
                        timer_clear  = 1'b1;
                        state_next   = ST_FETCH;
                        if (req_table != active_table_reg) begin
                            active_table_next = req_table;
                            rom_addr_next     = base_of(req_table);
                            idx_next          = '0;
                        end else if (last_reg || idx_reg == IDX_W'(MAX_ENTRIES - 1)) begin
                            rom_addr_next = base_of(active_table_reg);
                            idx_next      = '0;
                        end else begin
                            rom_addr_next = rom_addr_reg + ADDR_W'(1);
                            idx_next      = idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            rom_addr_reg     <= NORM_BASE;
            idx_reg          <= '0;
            hdr_id_reg       <= '0;
            slot_len_reg     <= '0;
            last_reg         <= 1'b0;
            active_table_reg <= TBL_NORM;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rom_addr_reg     <= rom_addr_next;
            idx_reg          <= idx_next;
            hdr_id_reg       <= hdr_id_next;
            slot_len_reg     <= slot_len_next;
            last_reg         <= last_next;
            active_table_reg <= active_table_next;
            overrun_reg      <= overrun_next;
        end
    end

    // Ticks and completions only matter while a slot is running, so a tick
    // coinciding with the ack is never counted.
    lin_slot_timer #(
        .SLOT_W(SLOT_W)
    ) u_slot_timer (
        .clk       (clk),
        .srst      (reset),
        .clear     (timer_clear),
        .load      (timer_load),
        .load_value(slot_len_reg),
        .tick      (tick && state_reg == ST_SLOT),
        .frame_done(frame_done && state_reg == ST_SLOT),
        .expired   (slot_expired),
        .done      (slot_done)
    );

    assign rom_addr     = rom_addr_reg;
    assign hdr_req      = (state_reg == ST_REQ);
    assign hdr_id       = hdr_id_reg;
    assign slot_overrun = overrun_reg;
    assign active_table = active_table_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_lin_schedule_sequencer.sv
// Randomized bench for lin_schedule_sequencer: a slot-level model of table
// walking and overrun detection predicts each header request.
module tb_lin_schedule_sequencer;

    logic        clk = 1'b0;
    logic        reset, en_operation, en_collision_table, en_diagnostic_table;
    logic        tick, hdr_ack, frame_done;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        hdr_req, slot_overrun, busy;
    logic [5:0]  hdr_id;
    logic [1:0]  active_table;

    logic [31:0] rom [0:255];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    lin_schedule_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .en_operation       (en_operation),
        .en_collision_table (en_collision_table),
        .en_diagnostic_table(en_diagnostic_table),
        .tick               (tick),
        .rom_addr           (rom_addr),
        .rom_data           (rom_data),
        .hdr_req            (hdr_req),
        .hdr_id             (hdr_id),
        .hdr_ack            (hdr_ack),
        .frame_done         (frame_done),
        .slot_overrun       (slot_overrun),
        .active_table       (active_table),
        .busy               (busy)
    );

    int checks   = 0;
    int failures = 0;
    int m_tbl    = 0;
    int m_idx    = 0;
    bit expect_prompt = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tbl_base(input int t);
        return (t == 2) ? 8'h80 : (t == 1) ? 8'h40 : 8'h00;
    endfunction

    function automatic logic [31:0] make_entry(input int id, input int len, input bit last);
        logic [31:0] e;
        e        = $urandom;
        e[5:0]   = 6'(id);
        e[15:8]  = 8'(len);
        e[16]    = last;
        return e;
    endfunction

    function automatic void model_start(input bit coll, input bit diag);
        m_tbl = diag ? 2 : (coll ? 1 : 0);
        m_idx = 0;
    endfunction

    function automatic void model_slot_end(input bit coll, input bit diag);
        int want;
        logic [31:0] e;
        want = diag ? 2 : (coll ? 1 : 0);
        e    = rom[tbl_base(m_tbl) + m_idx];
        if (want != m_tbl) begin
            m_tbl = want;
            m_idx = 0;
        end else if (e[16] || m_idx == 31) begin
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rom_addr"}, rom_addr, 0);
        check_eq({tag, "_hdr_req"}, hdr_req, 0);
        check_eq({tag, "_hdr_id"}, hdr_id, 0);
        check_eq({tag, "_overrun"}, slot_overrun, 0);
        check_eq({tag, "_active_table"}, active_table, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // One full slot: wait for the request, ack it, tick out the slot length and
    // check the slot-end timing; table inputs change on the first slot tick.
    task automatic run_slot(input bit give_done, input bit new_coll, input bit new_diag);
        int waited = 0;
        int addr, len;
        logic [31:0] e;
        @(negedge clk);
        while (hdr_req !== 1'b1 && waited < 8) begin
            step();
            @(negedge clk);
            waited++;
        end
        check_eq("req_seen", hdr_req, 1);
        if (expect_prompt) check_eq("req_latency", waited, 0);
        addr = tbl_base(m_tbl) + m_idx;
        e    = rom[addr];
        len  = (e[15:8] == 0) ? 1 : int'(e[15:8]);
        check_eq("rom_addr", rom_addr, addr);
        check_eq("hdr_id", hdr_id, e[5:0]);
        check_eq("active_table", active_table, m_tbl);
        repeat ($urandom_range(0, 2)) begin
            step();
            @(negedge clk);
            check_eq("req_hold", hdr_req, 1);
            check_eq("id_hold", hdr_id, e[5:0]);
        end
        step();
        hdr_ack = 1'b1;
        tick    = 1'($urandom_range(0, 1));
        step();
        hdr_ack    = 1'b0;
        tick       = 1'b0;
        frame_done = give_done;
        for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                frame_done = 1'b0;
            end
            tick = 1'b1;
            if (k == 0) begin
                en_collision_table  = new_coll;
                en_diagnostic_table = new_diag;
            end
            step();
            tick       = 1'b0;
            frame_done = 1'b0;
        end
        // A completion after the count hit zero must not rescue the slot.
        frame_done = !give_done;
        @(negedge clk);
        check_eq("ovr_early", slot_overrun, 0);
        check_eq("req_gap", hdr_req, 0);
        step();
        frame_done = 1'b0;
        @(negedge clk);
        check_eq("slot_overrun", slot_overrun, !give_done);
        check_eq("fetch_req", hdr_req, 0);
        $display("slot addr=0x%02h id=0x%02h len=%0d done=%0d overrun=%0d tbl=%0d",
                 addr, e[5:0], len, give_done, slot_overrun, m_tbl);
        model_slot_end(new_coll, new_diag);
        step();
        expect_prompt = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = make_entry($urandom_range(0, 63), 3, 1'b0);
        rom[8'h00] = make_entry(6'h10, 2, 1'b0);
        rom[8'h01] = make_entry(6'h11, 2, 1'b0);
        rom[8'h02] = make_entry(6'h12, 2, 1'b1);
        rom[8'h40] = make_entry($urandom_range(0, 63), 3, 1'b0);
        rom[8'h41] = make_entry($urandom_range(0, 63), 0, 1'b0);
        rom[8'h42] = make_entry($urandom_range(0, 63), $urandom_range(1, 3), 1'b1);
        for (int i = 8'h80; i < 8'hA0; i++)
            rom[i] = make_entry($urandom_range(0, 63), $urandom_range(0, 2), 1'b0);
        rom[8'h81] = make_entry(6'h2A, 0, 1'b0);

        reset = 1'b1; en_operation = 1'b0; en_collision_table = 1'b0;
        en_diagnostic_table = 1'b0; tick = 1'b0; hdr_ack = 1'b0; frame_done = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        reset        = 1'b0;
        en_operation = 1'b1;
        step();
        @(negedge clk);
        check_eq("start_busy", busy, 1);
        check_eq("start_fetch_req", hdr_req, 0);
        check_eq("start_addr", rom_addr, 8'h00);
        step();
        model_start(1'b0, 1'b0);
        expect_prompt = 1'b1;

        repeat (4) run_slot(1'b1, 1'b0, 1'b0);
        run_slot(1'b0, 1'b0, 1'b0);
        run_slot(1'b1, 1'b1, 1'b0);
        run_slot(1'b0, 1'b1, 1'b0);
        repeat (4) run_slot(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        run_slot(1'b1, 1'b1, 1'b1);
        repeat (34) run_slot(1'($urandom_range(0, 1)), 1'b1, 1'b1);

        // Drop enable while a request is outstanding and never acked.
        en_operation = 1'b0;
        step();
        @(negedge clk);
        check_eq("drop_req", hdr_req, 0);
        check_eq("drop_busy", busy, 0);
        en_collision_table  = 1'b0;
        en_diagnostic_table = 1'b0;
        step();
        en_operation = 1'b1;
        step();
        @(negedge clk);
        check_eq("restart_addr", rom_addr, 8'h00);
        check_eq("restart_table", active_table, 0);
        step();
        model_start(1'b0, 1'b0);
        expect_prompt = 1'b1;
        run_slot(1'b1, 1'b0, 1'b0);

        // Ack and enable fall in the same cycle: the slot must not start.
        hdr_ack      = 1'b1;
        en_operation = 1'b0;
        step();
        hdr_ack = 1'b0;
        @(negedge clk);
        check_eq("ack_vs_fall_busy", busy, 0);
        step();
        @(negedge clk);
        check_eq("ack_vs_fall_req", hdr_req, 0);

        // Restart on the collision table, then reset in the middle of its slot.
        en_collision_table = 1'b1;
        en_operation       = 1'b1;
        step();
        step();
        @(negedge clk);
        check_eq("coll_start_req", hdr_req, 1);
        check_eq("coll_start_addr", rom_addr, 8'h40);
        check_eq("coll_start_tbl", active_table, 1);
        step();
        hdr_ack = 1'b1;
        step();
        hdr_ack = 1'b0;
        @(negedge clk);
        check_eq("mid_slot_busy", busy, 1);
        step();
        reset   = 1'b1;
        tick    = 1'b1;
        hdr_ack = 1'b1;
        step();
        reset        = 1'b0;
        tick         = 1'b0;
        hdr_ack      = 1'b0;
        en_operation = 1'b0;
        @(negedge clk);
        check_reset_outputs("midslot_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lin_schedule_sequencer.md
# lin_schedule_sequencer

LIN master schedule sequencer: walks a schedule table held in a 32-bit combinational schedule ROM and issues one frame-header request per slot to the LIN frame engine. It also times each slot in base ticks and switches between the normal, collision-resolution and diagnostic tables at slot boundaries. It sits between the master controller (enable/table-select outputs) and the header transmitter.

## Interface
- ADDR_W, 8: ROM address width.
- SLOT_W, 8: slot-length field and counter width, in ticks.
- NORM_BASE, 8'h00: first ROM address of the normal table.
- COLL_BASE, 8'h40: first ROM address of the collision table.
- DIAG_BASE, 8'h80: first ROM address of the diagnostic table.
- MAX_ENTRIES, 32: hard wrap limit per table.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- en_operation  in  1  run enable from the master controller.
- en_collision_table  in  1  request for the collision table.
- en_diagnostic_table  in  1  request for the diagnostic table.
- tick  in  1  one-cycle base-time strobe (1 ms).
- rom_addr  out  ADDR_W  schedule ROM address; registered.
- rom_data  in  32  ROM entry: [5:0] frame ID, [15:8] slot length, [16] last-entry flag, rest reserved.
- hdr_req  out  1  header request; held until acknowledged.
- hdr_id  out  6  frame ID; stable while hdr_req=1.
- hdr_ack  in  1  header accepted by the frame engine.
- frame_done  in  1  one-cycle pulse when the response is complete.
- slot_overrun  out  1  one-cycle pulse when a slot expires before frame_done.
- active_table  out  2  00 normal, 01 collision, 10 diagnostic.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, FETCH, REQ, SLOT.
- IDLE:
  - hdr_req=0.
  - When en_operation=1, select a table by priority diagnostic > collision > normal.
  - Set rom_addr to that table's base and go to FETCH.
- FETCH:
  - rom_data is valid this cycle.
  - Latch the ID, slot length and last flag.
  - A slot length of 0 is loaded as 1.
  - Go to REQ.
- REQ:
  - Drive hdr_req=1 and hdr_id = latched ID.
  - On hdr_ack=1, go to SLOT and load the slot counter with the slot length.
  - The first tick counts from the cycle after the ack.
- SLOT:
  - The counter decrements on each tick; it never goes below 0.
  - Record frame_done in a done flag.
  - The slot ends when the counter is 0. If done=0 at that point, pulse slot_overrun.
  - frame_done after the counter reaches 0 is ignored.
- Slot end:
  - Re-evaluate the table requests. A table change loads that table's base address.
  - Otherwise, if the last flag is set, or the entry index equals MAX_ENTRIES-1, load the current base (wrap).
  - Otherwise, rom_addr+1.
  - Then go to FETCH.
- Table-select inputs are sampled only in IDLE and at slot end, never mid-slot.
- en_operation=0 in any state:
  - Go to IDLE next cycle, drop hdr_req and clear the counter and done flag.
  - An outstanding request is abandoned.
- Simultaneous hdr_ack and en_operation fall: the fall wins; do not enter SLOT.
- Simultaneous tick and hdr_ack: the tick is not counted.

## Timing
- Reset values: state IDLE, rom_addr=NORM_BASE, hdr_req=0, hdr_id=0, slot_overrun=0, active_table=00, busy=0, counter 0, done flag 0. Reset overrides all inputs.
- Start latency:
  - en_operation sampled high in IDLE at edge 0.
  - FETCH during cycle 1.
  - hdr_req=1 from edge 2.
- After the ack edge, the slot lasts the slot length in ticks.
- The next hdr_req rises 2 cycles after the slot-end edge (FETCH, then REQ).
- slot_overrun is exactly one cycle wide, registered, and coincides with the FETCH cycle.

## Structure
- Shared package lin_sched_pkg holds:
  - State encoding.
  - Table codes TBL_NORM/TBL_COLL/TBL_DIAG.
  - Entry field positions: ID_LSB/MSB, SLOT_LSB/MSB, LAST_BIT.
- One sub-module, lin_slot_timer: load/tick/clear counter that outputs expired, plus the done flag.

## Test plan
- Normal table with 3 entries (ID 0x10/0x11/0x12, slot 2, last on the third), en_operation=1, immediate acks, frame_done each slot:
  - Expect IDs 10,11,12,10.
  - Expect rom_addr to wrap to 0x00.
  - Expect no slot_overrun.
- en_collision_table raised mid-slot:
  - The current slot completes.
  - Next rom_addr=0x40 and active_table=01.
  - Both diagnostic and collision requests high at slot end → 0x80, active_table=10.
- Slot length 3 with frame_done never asserted:
  - slot_overrun pulses once, 3 ticks after the ack.
  - The next entry is fetched.
- Slot length 0 → behaves as 1 tick.
- No last flag anywhere in the table → wrap after MAX_ENTRIES entries.
- en_operation dropped while hdr_req=1 without an ack:
  - Next cycle hdr_req=0, busy=0.
  - Re-enable restarts at the table base.
- reset asserted during SLOT with a tick and hdr_ack active → all outputs return to their reset values on the next edge.
